// File: rtl/pair_sum_accum_if.sv
// pair_sum_accum_if: operand-pair input handshake and result output handshake
// for pair_sum_accum. The master side (producer/consumer) drives the operand
// pair and out_ready; the slave side (the accumulator stage) drives in_ready
// and the result channel. dbg_state mirrors the stage FSM (0 = IDLE, 1 = ACCUM).
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. A producer holding valid high keeps its payload stable until
// the transfer. in_ready depends only on registered FIFO occupancy, never on
// in_valid or out_ready in the same cycle.
interface pair_sum_accum_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sum;
    logic              out_ovf;
    logic              dbg_state;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, dbg_state
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, dbg_state
    );
endinterface

// File: rtl/pair_sum_accum.sv
// pair_sum_accum: adds each accepted operand pair and accumulates the sums over
// a group of BEATS pairs (or fewer when in_last ends the group). Every
// completed group is pushed as {sum, sticky overflow} into a 2-entry FIFO.
// Optional feature macro: PAIR_SUM_ACCUM_SAT_EN -- when defined, an overflowing
// beat clamps the accumulator to all-ones; otherwise the accumulator wraps.
module pair_sum_accum #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 10,
    parameter int BEATS  = 4
) (
    input logic            clk,
    input logic            rst,
    pair_sum_accum_if.slave bus
);
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [OUT_W-1:0]   fifo_sum_q [2];
    logic [OUT_W-1:0]   fifo_sum_d [2];
    logic               fifo_ovf_q [2];
    logic               fifo_ovf_d [2];
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [1:0]         count_q, count_d;

    logic               in_ready_w;
    logic               accept;
    logic               last_beat;
    logic               complete;
    logic               pop;
    logic [DATA_W:0]    pair;
    logic [OUT_W:0]     nxt;
    logic               beat_ovf;
    logic [OUT_W-1:0]   acc_upd;
    logic               ovf_upd;

    // Pair sum, widened accumulate, overflow detection and handshake qualifiers.
    always_comb begin
        in_ready_w = (count_q != 2'd2);
        accept     = bus.in_valid && in_ready_w;
        pair       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        nxt        = {1'b0, acc_q} + {{(OUT_W-DATA_W){1'b0}}, pair};
        beat_ovf   = nxt[OUT_W];
`ifdef PAIR_SUM_ACCUM_SAT_EN
        acc_upd    = beat_ovf ? {OUT_W{1'b1}} : nxt[OUT_W-1:0];
`else
        acc_upd    = nxt[OUT_W-1:0];
`endif
        ovf_upd    = ovf_q | beat_ovf;
        last_beat  = (cnt_q == CNT_W'(BEATS-1)) || bus.in_last;
        complete   = accept && last_beat;
        pop        = (count_q != 2'd0) && bus.out_ready;
    end

    // FSM next state and accumulator/beat-counter updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (accept) begin
            if (last_beat) begin
                // Group done: result leaves via the FIFO, accumulator restarts.
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_upd;
                cnt_d   = cnt_q + 1'b1;
                ovf_d   = ovf_upd;
            end
        end
    end

    // FIFO write/read pointers and occupancy; a push never targets a full FIFO
    // because accepts are blocked whenever count is 2.
    always_comb begin
        fifo_sum_d = fifo_sum_q;
        fifo_ovf_d = fifo_ovf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (complete) begin
            fifo_sum_d[tail_q] = acc_upd;
            fifo_ovf_d[tail_q] = ovf_upd;
            tail_d             = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({complete, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any partial group and all FIFO entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_sum_q[i] <= '0;
                fifo_ovf_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fifo_sum_q <= fifo_sum_d;
            fifo_ovf_q <= fifo_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_sum   = fifo_sum_q[head_q];
    assign bus.out_ovf   = fifo_ovf_q[head_q];
    assign bus.dbg_state = (state_q == ACCUM);
endmodule

// File: tb/tb_pair_sum_accum.sv
// tb_pair_sum_accum: directed and randomized stimulus for pair_sum_accum with a
// queue-based scoreboard. Directed groups push hand-computed results; the
// random phase uses a group-level arithmetic model of the accumulator.
module tb_pair_sum_accum;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 10;
    localparam int BEATS  = 4;
    localparam int MAXV   = (1 << OUT_W) - 1;

    logic clk;
    logic rst;

    pair_sum_accum_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    pair_sum_accum #(.DATA_W(DATA_W), .OUT_W(OUT_W), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [OUT_W:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit use_model = 1'b0;
    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_result(input int sum, input bit ovf);
        exp_q.push_back({ovf, OUT_W'(sum)});
    endtask

    // Group-level reference: running sum with overflow test against the
    // result range, then wrap or clamp of the kept value.
    task automatic model_accept(input int a, input int b, input bit last);
        int s;
        s = m_acc + a + b;
        if (s > MAXV) m_ovf = 1'b1;
`ifdef PAIR_SUM_ACCUM_SAT_EN
        m_acc = (s > MAXV) ? MAXV : s;
`else
        m_acc = s % (MAXV + 1);
`endif
        m_cnt++;
        if (m_cnt == BEATS || last) begin
            expect_result(m_acc, m_ovf);
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    always begin
        logic [OUT_W:0] e;
        @(negedge clk);
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum=%0d ovf=%0d expected none", bus.out_sum, bus.out_ovf);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", 32'(bus.out_sum), 32'(e[OUT_W-1:0]));
                check("out_ovf", 32'(bus.out_ovf), 32'(e[OUT_W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // rdy < 0 leaves out_ready alone; 0/1 sets it on the same cycle as the pair.
    task automatic send_pair(input int a, input int b, input bit last, input int rdy);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = DATA_W'(a);
        bus.in_b     = DATA_W'(b);
        bus.in_last  = last;
        if (rdy >= 0) bus.out_ready = rdy[0];
        n = 0;
        while (!bus.in_ready && n < 50) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (use_model) model_accept(a, b, last);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic send_group(input int a, input int b, input int rdy);
        for (int i = 0; i < BEATS; i++) send_pair(a, b, 1'b0, rdy);
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.out_valid || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 1);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_sum", 32'(bus.out_sum), 0);
        check("reset_out_ovf", 32'(bus.out_ovf), 0);
        check("reset_state", 32'(bus.dbg_state), 0);
        rst = 1'b0;

        // Basic group and result latency.
        expect_result(36, 1'b0);
        send_pair(1, 2, 1'b0, 1);
        check("state_accum", 32'(bus.dbg_state), 1);
        send_pair(3, 4, 1'b0, 1);
        send_pair(5, 6, 1'b0, 1);
        check("latency_before", 32'(bus.out_valid), 0);
        send_pair(7, 8, 1'b0, 1);
        check("latency_after", 32'(bus.out_valid), 1);
        check("state_idle", 32'(bus.dbg_state), 0);

        // Overflow, then a clean group.
`ifdef PAIR_SUM_ACCUM_SAT_EN
        expect_result(1023, 1'b1);
`else
        expect_result(1016, 1'b1);
`endif
        send_group(255, 255, 1);
        expect_result(4, 1'b0);
        send_group(0, 1, 1);

        // Early end, then a full group to show the counter restarted.
        expect_result(100, 1'b0);
        send_pair(10, 20, 1'b0, 1);
        send_pair(30, 40, 1'b1, 1);
        expect_result(8, 1'b0);
        send_group(1, 1, 1);
        drain();

        // Backpressure: two results fill the FIFO, third group waits.
        expect_result(4, 1'b0);
        expect_result(4, 1'b0);
        expect_result(4, 1'b0);
        send_group(1, 0, 0);
        send_group(1, 0, 0);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_out_valid", 32'(bus.out_valid), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_pop", 32'(bus.in_ready), 1);
        send_group(1, 0, 1);
        drain();

        // Push and pop on the same edge with one entry held.
        expect_result(4, 1'b0);
        expect_result(8, 1'b0);
        send_group(1, 0, 0);
        send_pair(2, 0, 1'b0, 0);
        send_pair(2, 0, 1'b0, 0);
        send_pair(2, 0, 1'b0, 0);
        send_pair(2, 0, 1'b0, 1);
        check("pushpop_out_valid", 32'(bus.out_valid), 1);
        check("pushpop_in_ready", 32'(bus.in_ready), 1);
        drain();

        // Reset with one result queued and a partial group held.
        send_group(1, 1, 0);
        send_pair(5, 5, 1'b0, 0);
        send_pair(5, 5, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_state", 32'(bus.dbg_state), 0);
        @(negedge clk);
        rst = 1'b0;
        expect_result(20, 1'b0);
        send_group(2, 3, 1);
        drain();

        // Randomized groups against the reference model.
        use_model = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < 80; i++) begin
            send_pair($urandom_range(0, 255), $urandom_range(0, 255),
                      ($urandom_range(0, 4) == 0), $urandom_range(0, 1));
        end
        if (m_cnt != 0) send_pair($urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1);
        drain();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
